// File: rtl/sr_latch.sv
// rtl/sr_latch.sv - Clocked set/reset latch with request synchronisers and complementary outputs.
// Requests are level-sensitive; SET_DOMINANT resolves simultaneous set and reset.
module sr_latch #(
    parameter int SYNC_STAGES  = 2,
    parameter bit SET_DOMINANT = 1'b0,
    parameter bit RESET_Q      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic reset,
    output logic q,
    output logic qNot,
    output logic conflict
);

    logic set_s;
    logic reset_s;
    logic q_q;
    logic q_d;
    logic conflict_q;
    logic conflict_d;

    // Both requests use identical chains so their relative ordering is preserved.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign set_s   = set;
            assign reset_s = reset;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] set_sync_q;
            logic [SYNC_STAGES-1:0] reset_sync_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    set_sync_q   <= '0;
                    reset_sync_q <= '0;
                end else begin
                    set_sync_q[0]   <= set;
                    reset_sync_q[0] <= reset;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        set_sync_q[i]   <= set_sync_q[i-1];
                        reset_sync_q[i] <= reset_sync_q[i-1];
                    end
                end
            end

            assign set_s   = set_sync_q[SYNC_STAGES-1];
            assign reset_s = reset_sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        q_d        = q_q;
        conflict_d = 1'b0;
        case ({set_s, reset_s})
            2'b10:   q_d = 1'b1;
            2'b01:   q_d = 1'b0;
            2'b11: begin
                q_d        = SET_DOMINANT;
                conflict_d = 1'b1;
            end
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q        <= RESET_Q;
            conflict_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            conflict_q <= conflict_d;
        end
    end

    // qNot is derived from the same flop so q == qNot can never be observed.
    assign q        = q_q;
    assign qNot     = ~q_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_latch.sv
// tb/tb_sr_latch.sv - Scoreboard bench for sr_latch: default, set-dominant and unsynchronised variants.
// Each vector row holds inputs, run length and hand-computed outputs for the three instances.
module tb_sr_latch;

    typedef struct packed {
        logic       s;
        logic       r;
        logic       rp;
        logic [7:0] n;
        logic       q;
        logic       c;
        logic       qd;
        logic       cd;
        logic       q0;
        logic       c0;
    } vec_t;

    typedef struct {
        int         row;
        logic [2:0] q;
        logic [2:0] c;
    } exp_t;

    logic clk;
    logic clk_en;
    logic rst;
    logic set;
    logic reset;
    logic [2:0] q_o;
    logic [2:0] qn_o;
    logic [2:0] c_o;

    int   passed;
    int   total;
    vec_t vecs[$];
    exp_t sb[$];

    sr_latch u_def (
        .clk(clk), .rst(rst), .set(set), .reset(reset),
        .q(q_o[0]), .qNot(qn_o[0]), .conflict(c_o[0])
    );

    sr_latch #(.SET_DOMINANT(1'b1)) u_sd (
        .clk(clk), .rst(rst), .set(set), .reset(reset),
        .q(q_o[1]), .qNot(qn_o[1]), .conflict(c_o[1])
    );

    sr_latch #(.SYNC_STAGES(0)) u_s0 (
        .clk(clk), .rst(rst), .set(set), .reset(reset),
        .q(q_o[2]), .qNot(qn_o[2]), .conflict(c_o[2])
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b", name, act, exp);
        else
            passed++;
    endtask

    function automatic vec_t v(input logic s, input logic r, input logic rp, input int n,
                               input logic q, input logic c, input logic qd, input logic cd,
                               input logic q0, input logic c0);
        vec_t t;
        t.s = s; t.r = r; t.rp = rp; t.n = 8'(n);
        t.q = q; t.c = c; t.qd = qd; t.cd = cd; t.q0 = q0; t.c0 = c0;
        return t;
    endfunction

    task automatic chk_reset_state(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s q[%0d]", tag, d), q_o[d], 1'b0);
            chk($sformatf("%s qNot[%0d]", tag, d), qn_o[d], 1'b1);
            chk($sformatf("%s conflict[%0d]", tag, d), c_o[d], 1'b0);
        end
    endtask

    // Monitor: one output observation per rising edge, taken 2 ns after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int d = 0; d < 3; d++) begin
                    chk($sformatf("row%0d q[%0d]", e.row, d), q_o[d], e.q[d]);
                    chk($sformatf("row%0d qNot[%0d]", e.row, d), qn_o[d], ~e.q[d]);
                    chk($sformatf("row%0d conflict[%0d]", e.row, d), c_o[d], e.c[d]);
                end
            end
        end
    end

    initial begin
        exp_t e;
        passed = 0;
        total  = 0;
        set    = 1'b0;
        reset  = 1'b0;
        rst    = 1'b0;
        clk_en = 1'b0;

        // Default instance lags two observations; SYNC_STAGES=0 instance lags none.
        vecs.push_back(v(0,0,0, 5, 0,0, 0,0, 0,0));
        vecs.push_back(v(1,0,0, 2, 0,0, 0,0, 1,0));
        vecs.push_back(v(1,0,0,18, 1,0, 1,0, 1,0));
        vecs.push_back(v(0,1,0, 2, 1,0, 1,0, 0,0));
        vecs.push_back(v(0,1,0,18, 0,0, 0,0, 0,0));
        vecs.push_back(v(0,0,0, 2, 0,0, 0,0, 0,0));
        vecs.push_back(v(0,0,0, 8, 0,0, 0,0, 0,0));
        vecs.push_back(v(1,0,0, 2, 0,0, 0,0, 1,0));
        vecs.push_back(v(1,0,0,18, 1,0, 1,0, 1,0));
        vecs.push_back(v(0,0,0, 2, 1,0, 1,0, 1,0));
        vecs.push_back(v(0,0,0, 8, 1,0, 1,0, 1,0));
        vecs.push_back(v(1,1,0, 2, 1,0, 1,0, 0,1));
        vecs.push_back(v(1,1,0, 2, 0,1, 1,1, 0,1));
        vecs.push_back(v(0,0,0, 2, 0,1, 1,1, 0,0));
        vecs.push_back(v(0,0,0, 6, 0,0, 1,0, 0,0));
        vecs.push_back(v(1,0,0, 1, 0,0, 1,0, 1,0));
        vecs.push_back(v(0,0,0, 1, 0,0, 1,0, 1,0));
        vecs.push_back(v(0,0,0,10, 1,0, 1,0, 1,0));
        vecs.push_back(v(0,1,0, 2, 1,0, 1,0, 0,0));
        vecs.push_back(v(0,1,0, 3, 0,0, 0,0, 0,0));
        vecs.push_back(v(0,0,0, 2, 0,0, 0,0, 0,0));
        vecs.push_back(v(1,0,0, 1, 0,0, 0,0, 1,0));
        vecs.push_back(v(0,1,0, 1, 0,0, 0,0, 0,0));
        vecs.push_back(v(0,0,0, 1, 1,0, 1,0, 0,0));
        vecs.push_back(v(0,0,0, 1, 0,0, 0,0, 0,0));
        vecs.push_back(v(0,0,0, 5, 0,0, 0,0, 0,0));
        vecs.push_back(v(1,0,0, 2, 0,0, 0,0, 1,0));
        vecs.push_back(v(1,0,0, 5, 1,0, 1,0, 1,0));
        vecs.push_back(v(1,0,1, 1, 0,0, 0,0, 1,0));
        vecs.push_back(v(1,0,0, 1, 0,0, 0,0, 1,0));
        vecs.push_back(v(1,0,0, 5, 1,0, 1,0, 1,0));
        vecs.push_back(v(0,1,0, 2, 1,0, 1,0, 0,0));
        vecs.push_back(v(0,1,0, 3, 0,0, 0,0, 0,0));

        // Reset with the clock stopped must take effect immediately.
        #3 rst = 1'b1;
        #1 chk_reset_state("por");
        #5 rst = 1'b0;
        clk_en = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < int'(vecs[i].n); k++) begin
                @(negedge clk);
                set   = vecs[i].s;
                reset = vecs[i].r;
                e.row = i + 1;
                e.q   = {vecs[i].q0, vecs[i].qd, vecs[i].q};
                e.c   = {vecs[i].c0, vecs[i].cd, vecs[i].c};
                sb.push_back(e);
                if (vecs[i].rp && k == 0) begin
                    #1 rst = 1'b1;
                    #1 chk_reset_state("midrst");
                    #1 rst = 1'b0;
                end
            end
        end

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
